// File: rtl/mod12_pkg.sv
// -----------------------------------------------------------------------------
// mod12_pkg
// Shared types and defaults for the mod-12 wrap tracker slice.
//   MOD_DEFAULT       modulus of the upstream counter (legal values 0..MOD-1)
//   WRAP_MOD_DEFAULT  modulus of the wrap cascade stage
//   WRAP_W_DEFAULT    width of the wrap count
//   state_t           tracker FSM state, 2-bit encoded (IDLE=0, RUN=1, ERR=2)
//   bcd_t             one BCD-split count value (tens digit, ones digit)
// -----------------------------------------------------------------------------
package mod12_pkg;

  localparam int MOD_DEFAULT      = 12;
  localparam int WRAP_MOD_DEFAULT = 5;
  localparam int WRAP_W_DEFAULT   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic       tens;
    logic [3:0] ones;
  } bcd_t;

endpackage

// File: rtl/mod12_wrap_tracker_if.sv
// -----------------------------------------------------------------------------
// mod12_wrap_tracker_if
// Bundle between the upstream mod-12 counter side and the wrap tracker.
//   count_in    upstream count (bit 3 = Qd .. bit 0 = Qa)
//   bcd_tens    tens digit of the last accepted count
//   bcd_ones    ones digit of the last accepted count
//   wrap_pulse  one-cycle pulse per upstream 11->0 wrap
//   wraps       wrap count modulo WRAP_MOD
//   carry_out   one-cycle pulse when wraps rolls over
//   err         sticky error flag
//   state_o     tracker FSM state, for debug
// Modports: master = counter/consumer side, slave = the tracker.
// -----------------------------------------------------------------------------
interface mod12_wrap_tracker_if #(
  parameter int WRAP_W = 3
);

  logic [3:0]        count_in;
  logic              bcd_tens;
  logic [3:0]        bcd_ones;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wraps;
  logic              carry_out;
  logic              err;
  logic [1:0]        state_o;

  modport master (
    output count_in,
    input  bcd_tens, bcd_ones, wrap_pulse, wraps, carry_out, err, state_o
  );

  modport slave (
    input  count_in,
    output bcd_tens, bcd_ones, wrap_pulse, wraps, carry_out, err, state_o
  );

endinterface

// File: rtl/mod12_bcd_split.sv
// -----------------------------------------------------------------------------
// mod12_bcd_split
// Combinational split of a 4-bit binary value into tens/ones BCD digits.
//   v  in   4-bit binary value
//   d  out  {tens, ones}; v >= 10 gives tens=1, ones=v-10
// -----------------------------------------------------------------------------
module mod12_bcd_split
  import mod12_pkg::*;
(
  input  logic [3:0] v,
  output bcd_t       d
);

  // Tens/ones split; values 10..15 map to tens=1
  always_comb begin
    d = '{tens: 1'b0, ones: 4'd0};
    if (v >= 4'd10) begin
      d.tens = 1'b1;
      d.ones = v - 4'd10;
    end else begin
      d.tens = 1'b0;
      d.ones = v;
    end
  end

endmodule

// File: rtl/mod12_wrap_tracker.sv
// -----------------------------------------------------------------------------
// mod12_wrap_tracker
// Watches a mod-MOD up counter: checks the range, detects MOD-1 -> 0 wraps,
// counts wraps modulo WRAP_MOD (carry on rollover) and keeps a registered BCD
// copy of the last accepted count. Any illegal value latches a sticky error
// that only clr clears.
//   clk  in  rising-edge clock shared with the upstream counter
//   clr  in  synchronous active-high reset (same net as the counter's clr)
//   bus  slave modport of mod12_wrap_tracker_if (count in, status out)
// Build option: MOD12_SEQ_CHECK_EN -- when defined, any in-range RUN transition
// that is not hold, step or wrap also goes to ERR.
// All outputs are registered (1-cycle latency from count_in sampling).
// -----------------------------------------------------------------------------
module mod12_wrap_tracker
  import mod12_pkg::*;
#(
  parameter int MOD      = MOD_DEFAULT,
  parameter int WRAP_MOD = WRAP_MOD_DEFAULT,
  parameter int WRAP_W   = WRAP_W_DEFAULT
)(
  input  logic                 clk,
  input  logic                 clr,
  mod12_wrap_tracker_if.slave  bus
);

  localparam logic [4:0]        MOD5     = 5'(MOD);
  localparam logic [3:0]        MAX4     = 4'(MOD - 1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = WRAP_W'(WRAP_MOD - 1);

  state_t            state_r, state_s;
  logic [3:0]        prev_r, prev_s;
  logic [WRAP_W-1:0] wraps_r, wraps_s;
  bcd_t              bcd_r, bcd_s, split_s;
  logic              wrap_pulse_r, wrap_pulse_s;
  logic              carry_r, carry_s;
  logic              err_r, err_s;
  logic              accept_s;
  logic [4:0]        cin5_s, prev_inc_s;
  logic              range_err_s;

  mod12_bcd_split u_split (
    .v (bus.count_in),
    .d (split_s)
  );

  // 5-bit compare operands so prev+1 of 15 cannot alias to 0
  assign cin5_s      = {1'b0, bus.count_in};
  assign prev_inc_s  = {1'b0, prev_r} + 5'd1;
  assign range_err_s = (cin5_s >= MOD5);

  // Next-state, wrap counting and accept decision
  always_comb begin
    state_s      = state_r;
    prev_s       = prev_r;
    wraps_s      = wraps_r;
    bcd_s        = bcd_r;
    wrap_pulse_s = 1'b0;
    carry_s      = 1'b0;
    err_s        = err_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (range_err_s) begin
          state_s = ERR;
          err_s   = 1'b1;
        end else if (bus.count_in == 4'd0) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          // waiting for the counter to come round to 0
          state_s = IDLE;
        end
      end
      RUN: begin
        if (range_err_s) begin
          state_s = ERR;
          err_s   = 1'b1;
        end else if (bus.count_in == prev_r) begin
          accept_s = 1'b1;
        end else if ((prev_r == MAX4) && (bus.count_in == 4'd0)) begin
          accept_s     = 1'b1;
          wrap_pulse_s = 1'b1;
          // compare before incrementing; never rely on overflow
          if (wraps_r == WRAP_MAX) begin
            wraps_s = {WRAP_W{1'b0}};
            carry_s = 1'b1;
          end else begin
            wraps_s = wraps_r + WRAP_W'(1);
          end
        end else if ((prev_r < MAX4) && (cin5_s == prev_inc_s)) begin
          accept_s = 1'b1;
        end else begin
`ifdef MOD12_SEQ_CHECK_EN
          state_s = ERR;
          err_s   = 1'b1;
`else
          accept_s = 1'b1;
`endif
        end
      end
      ERR: begin
        // frozen until clr
        state_s = ERR;
        err_s   = 1'b1;
      end
      default: begin
        state_s = ERR;
        err_s   = 1'b1;
      end
    endcase
    if (accept_s) begin
      prev_s = bus.count_in;
      bcd_s  = split_s;
    end else begin
      prev_s = prev_r;
      bcd_s  = bcd_r;
    end
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r      <= IDLE;
      prev_r       <= 4'd0;
      wraps_r      <= {WRAP_W{1'b0}};
      bcd_r        <= '{tens: 1'b0, ones: 4'd0};
      wrap_pulse_r <= 1'b0;
      carry_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      prev_r       <= prev_s;
      wraps_r      <= wraps_s;
      bcd_r        <= bcd_s;
      wrap_pulse_r <= wrap_pulse_s;
      carry_r      <= carry_s;
      err_r        <= err_s;
    end
  end

  assign bus.bcd_tens   = bcd_r.tens;
  assign bus.bcd_ones   = bcd_r.ones;
  assign bus.wrap_pulse = wrap_pulse_r;
  assign bus.wraps      = wraps_r;
  assign bus.carry_out  = carry_r;
  assign bus.err        = err_r;
  assign bus.state_o    = state_r;

endmodule

// File: tb/tb_mod12_wrap_tracker.sv
// -----------------------------------------------------------------------------
// tb_mod12_wrap_tracker
// Self-checking bench for mod12_wrap_tracker: a vector table for reset,
// alignment, range and sequence cases, then free-running counter sequences
// for wrap/carry, error freeze and clr-on-wrap. Expected outputs are queued
// when a value is driven and compared after the sampling edge.
// -----------------------------------------------------------------------------
module tb_mod12_wrap_tracker;
  import mod12_pkg::*;

  typedef struct packed {
    logic       tens;
    logic [3:0] ones;
    logic       wp;
    logic [2:0] wraps;
    logic       carry;
    logic       err;
    logic [1:0] st;
  } exp_t;

  typedef struct packed {
    logic       clr;
    logic [3:0] cin;
    exp_t       e;
  } vec_t;

  logic clk;
  logic clr;

  mod12_wrap_tracker_if #(.WRAP_W(3)) bus ();

  mod12_wrap_tracker #(.MOD(12), .WRAP_MOD(5), .WRAP_W(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  act_last;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_wp  = 0;
  int    n_cy  = 0;

  function automatic exp_t mk(input int tens, input int ones, input int wp,
                              input int wraps, input int carry, input int err,
                              input int st);
    exp_t e;
    e.tens  = 1'(tens);
    e.ones  = 4'(ones);
    e.wp    = 1'(wp);
    e.wraps = 3'(wraps);
    e.carry = 1'(carry);
    e.err   = 1'(err);
    e.st    = 2'(st);
    return e;
  endfunction

  function automatic vec_t mv(input int c, input int v, input exp_t e);
    vec_t r;
    r.clr = 1'(c);
    r.cin = 4'(v);
    r.e   = e;
    return r;
  endfunction

  task automatic step(input logic c, input logic [3:0] v, input exp_t e, input string nm);
    exp_t ex;
    string n;
    clr          = c;
    bus.count_in = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    act_last = {bus.bcd_tens, bus.bcd_ones, bus.wrap_pulse, bus.wraps,
                bus.carry_out, bus.err, bus.state_o};
    ex = exp_q.pop_front();
    n  = name_q.pop_front();
    n_cmp++;
    if (act_last !== ex) begin
      n_bad++;
      $display("FAIL %s (cin=%0d clr=%0b): got tens=%0d ones=%0d wp=%0b wraps=%0d carry=%0b err=%0b st=%0d, need tens=%0d ones=%0d wp=%0b wraps=%0d carry=%0b err=%0b st=%0d",
               n, v, c, act_last.tens, act_last.ones, act_last.wp, act_last.wraps,
               act_last.carry, act_last.err, act_last.st, ex.tens, ex.ones, ex.wp,
               ex.wraps, ex.carry, ex.err, ex.st);
    end
  endtask

  // Counter free-running from 0 right after a clr; expectations from count index
  task automatic free_run(input int n, input string nm);
    int c;
    for (int i = 0; i < n; i++) begin
      c = i % 12;
      step(1'b0, 4'(c),
           mk((c >= 10) ? 1 : 0, (c >= 10) ? c - 10 : c,
              (i > 0 && c == 0) ? 1 : 0, (i / 12) % 5,
              (i > 0 && (i % 60) == 0) ? 1 : 0, 0, 1),
           nm);
      if (act_last.wp)    n_wp++;
      if (act_last.carry) n_cy++;
    end
  endtask

  vec_t tbl[$];
  exp_t z;

  initial begin
    clr          = 1'b1;
    bus.count_in = 4'd0;
    z = mk(0, 0, 0, 0, 0, 0, 0);

    // reset, alignment wait, step/hold, sequence jump, range from IDLE
    tbl.push_back(mv(1, 0,  z));
    tbl.push_back(mv(0, 5,  z));
    tbl.push_back(mv(0, 5,  z));
    tbl.push_back(mv(0, 0,  mk(0, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(mv(0, 1,  mk(0, 1, 0, 0, 0, 0, 1)));
    tbl.push_back(mv(0, 1,  mk(0, 1, 0, 0, 0, 0, 1)));
    tbl.push_back(mv(0, 2,  mk(0, 2, 0, 0, 0, 0, 1)));
    tbl.push_back(mv(0, 3,  mk(0, 3, 0, 0, 0, 0, 1)));
`ifdef MOD12_SEQ_CHECK_EN
    tbl.push_back(mv(0, 7,  mk(0, 3, 0, 0, 0, 1, 2)));
    tbl.push_back(mv(0, 8,  mk(0, 3, 0, 0, 0, 1, 2)));
`else
    tbl.push_back(mv(0, 7,  mk(0, 7, 0, 0, 0, 0, 1)));
    tbl.push_back(mv(0, 8,  mk(0, 8, 0, 0, 0, 0, 1)));
`endif
    tbl.push_back(mv(1, 0,  z));
    tbl.push_back(mv(0, 12, mk(0, 0, 0, 0, 0, 1, 2)));
    tbl.push_back(mv(0, 0,  mk(0, 0, 0, 0, 0, 1, 2)));
    tbl.push_back(mv(1, 0,  z));
    tbl.push_back(mv(0, 10, z));
    tbl.push_back(mv(0, 0,  mk(0, 0, 0, 0, 0, 0, 1)));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].cin, tbl[i].e, $sformatf("table[%0d]", i));
    end

    // 60 counts: five wraps, one carry on the fifth
    step(1'b1, 4'd0, z, "clr_b");
    n_wp = 0;
    n_cy = 0;
    free_run(61, "free60");
    n_cmp++;
    if (n_wp != 5) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d pulses, need 5", n_wp);
    end
    n_cmp++;
    if (n_cy != 1) begin
      n_bad++;
      $display("FAIL carry_count: got %0d pulses, need 1", n_cy);
    end

    // range error with wraps=1 and count 2: everything freezes, clr recovers
    step(1'b1, 4'd0, z, "clr_c");
    free_run(15, "pre_err");
    step(1'b0, 4'd13, mk(0, 2, 0, 1, 0, 1, 2), "err_13");
    step(1'b0, 4'd0,  mk(0, 2, 0, 1, 0, 1, 2), "err_hold0");
    step(1'b0, 4'd11, mk(0, 2, 0, 1, 0, 1, 2), "err_hold11");
    step(1'b0, 4'd0,  mk(0, 2, 0, 1, 0, 1, 2), "err_nowrap");
    step(1'b1, 4'd0,  z, "err_clr");

    // clr on the same edge as an 11->0 wrap discards the wrap
    free_run(12, "pre_wrapclr");
    step(1'b1, 4'd0, z, "clr_on_wrap");
    step(1'b0, 4'd0, mk(0, 0, 0, 0, 0, 0, 1), "after_wrapclr");
    step(1'b0, 4'd1, mk(0, 1, 0, 0, 0, 0, 1), "after_wrapclr_1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
